mac_stream_loader: RTL
======================

# mac_stream_loader

Writer-side companion to the MAC controller: accepts a valid/ready byte stream, writes 8 weights into the W BRAM and 8 activations into the X BRAM through their write ports, pulses `start_o` to the controller, waits for `done_i`, and returns the 32-bit accumulator on a valid/ready result port. It sits between the host stream interface and the controller/BRAM/MAC datapath, so the datapath can be reloaded at run time instead of relying on init files.

## Interface
- `DATA_WIDTH`, 8: stream byte and BRAM word width.
- `DEPTH`, 8: entries per BRAM.
- `ADDR_WIDTH`, 3: BRAM address width; must equal clog2(`DEPTH`).
- `ACC_WIDTH`, 32: accumulator and result width.
- `TIMEOUT_CYC`, 255: watchdog limit in `WAIT_DONE`. Used only when `MAC_LOADER_TIMEOUT_EN` is defined.
- `clk_i` in 1: single clock. All logic is rising-edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `s_valid_i` in 1: stream beat valid.
- `s_data_i` in `DATA_WIDTH`: stream beat data.
- `s_ready_o` out 1: loader accepts a beat.
- `w_en_o` / `w_we_o` out 1: W BRAM port enable and write enable.
- `w_addr_o` out `ADDR_WIDTH`: W BRAM write address.
- `w_din_o` out `DATA_WIDTH`: W BRAM write data.
- `x_en_o` / `x_we_o` out 1: X BRAM port enable and write enable.
- `x_addr_o` out `ADDR_WIDTH`: X BRAM write address.
- `x_din_o` out `DATA_WIDTH`: X BRAM write data.
- `start_o` out 1: single-cycle start pulse to the controller.
- `done_i` in 1: controller completion.
- `acc_i` in `ACC_WIDTH`: MAC accumulator.
- `m_valid_o` out 1: result valid.
- `m_data_o` out `ACC_WIDTH`: captured result.
- `m_ready_i` in 1: result consumer ready.
- `busy_o` out 1: high in every state except `LOAD_W` with count 0.
- `timeout_o` out 1: single-cycle watchdog-expiry pulse.

## Operation
- **Handshake:** a beat transfers on a cycle with `s_valid_i & s_ready_o` high.
- **`s_ready_o`:** high only in `LOAD_W` and `LOAD_X`.
- **States:** `LOAD_W` → `LOAD_X` → `DRAIN` → `KICK` → `WAIT_DONE` → `RESULT` → `LOAD_W`.
- **`LOAD_W`:** each accepted beat registers a write into W BRAM at address `cnt` with data `s_data_i`, then increments `cnt`. When the beat at `cnt == DEPTH-1` is accepted: `cnt` wraps to 0 and the state moves to `LOAD_X`.
- **`LOAD_X`:** same as `LOAD_W`, but writes the X BRAM. When the beat at `cnt == DEPTH-1` is accepted, the state moves to `DRAIN`.
- **`DRAIN`:** one cycle, so the final X write commits before start.
- **`KICK`:** `start_o = 1` for exactly one cycle, then `WAIT_DONE`.
- **`WAIT_DONE`:** on `done_i`, capture `acc_i` into `m_data_o`, set `m_valid_o`, go to `RESULT`.
- **`RESULT`:** hold `m_valid_o` and `m_data_o` stable until `m_ready_i`. On that cycle, clear `m_valid_o` and return to `LOAD_W`.
- **Write strobes:** `en` and `we` are asserted together, one cycle per accepted beat. W and X strobes are never high in the same cycle.
- **Ignored inputs:**
  - `done_i` outside `WAIT_DONE` is ignored.
  - `s_valid_i` outside the load states is ignored (back-pressured by `s_ready_o = 0`).
- **Widths:** data passes unmodified; no arithmetic beyond the `ADDR_WIDTH` counter, which wraps modulo `DEPTH`.
- **Reset:**
  - `rst_i` asserted at any time, including mid-load or mid-wait, forces `LOAD_W` and `cnt = 0`.
  - All outputs go to 0; `m_data_o = 0`.
  - BRAM contents already written are not cleared.

## Timing
- **Write latency:** beat accepted at edge N; BRAM write strobe, address and data are registered and high during cycle N+1.
- **Start timing:** last X beat accepted at edge N; X write strobe in cycle N+1 (`DRAIN`); `start_o` high in cycle N+2.
- **Minimum load:** 16 cycles with `s_valid_i` held high.
- **Result latency:** `done_i` sampled at edge M; `m_valid_o` high from cycle M+1.
- **Next load:** `m_ready_i` sampled high at edge R; `s_ready_o` high from cycle R+1.
- **`m_ready_i`** may be high before `m_valid_o`. The transfer then completes one cycle after `m_valid_o` rises.

## Configuration
- **`MAC_LOADER_TIMEOUT_EN` defined:**
  - A counter runs in `WAIT_DONE`.
  - If `done_i` is not seen within `TIMEOUT_CYC` cycles: `timeout_o` pulses one cycle, the state returns to `LOAD_W`, and no result is produced.
  - `done_i` on the expiry cycle takes priority over the timeout.
- **Undefined:** `timeout_o` is tied to 0 and the loader waits indefinitely.

## Test plan
- **Basic load and result:** stream 0x01..0x08 then 0x11..0x18 with `s_valid_i` constantly high.
  - W addresses 0..7 receive 0x01..0x08 and X addresses 0..7 receive 0x11..0x18.
  - `start_o` pulses once, 2 cycles after the 16th beat.
  - After `done_i` with `acc_i = 0x0000_03C0`, `m_data_o = 0x3C0` with `m_valid_o` high.
- **Stream back-pressure:** random `s_valid_i` gaps during the load.
  - Writes occur only on accepted beats, addresses contiguous.
  - `s_ready_o = 0` from `DRAIN` through `RESULT`.
- **Result back-pressure:** `m_ready_i` held low 10 cycles after result.
  - `m_valid_o` and `m_data_o` stay stable.
  - Release → one transfer, then `s_ready_o = 1` the next cycle.
- **Spurious done:** `done_i` pulsed during `LOAD_X`.
  - No state change, no `m_valid_o`.
- **Reset mid-operation:** `rst_i` after 5 X beats.
  - All outputs 0.
  - Next 16-beat load restarts at W address 0.
- **Timeout (`MAC_LOADER_TIMEOUT_EN`):** no `done_i`.
  - `timeout_o` pulses exactly 255 cycles after `KICK`; loader returns to `LOAD_W`.
  - Without the macro, the loader stays in `WAIT_DONE`.

Source files
------------

// File: rtl/mac_stream_loader.sv
// Stream loader: fills the W/X BRAMs from a byte stream, kicks the MAC controller, returns the result.
// Optional WAIT_DONE watchdog enabled by defining MAC_LOADER_TIMEOUT_EN.
module mac_stream_loader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  w_en_o,
  output logic                  w_we_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [DATA_WIDTH-1:0] w_din_o,
  output logic                  x_en_o,
  output logic                  x_we_o,
  output logic [ADDR_WIDTH-1:0] x_addr_o,
  output logic [DATA_WIDTH-1:0] x_din_o,
  output logic                  start_o,
  input  logic                  done_i,
  input  logic [ACC_WIDTH-1:0]  acc_i,
  output logic                  m_valid_o,
  output logic [ACC_WIDTH-1:0]  m_data_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic [2:0] {
    StLoadW, StLoadX, StDrain, StKick, StWaitDone, StResult
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
`ifdef MAC_LOADER_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  w_wr_q, w_wr_d, x_wr_q, x_wr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  m_valid_q, m_valid_d;
  logic [ACC_WIDTH-1:0]  m_data_q, m_data_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  rdy;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_wr_d    = 1'b0;
    x_wr_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    tmo_d     = tmo_q;
    rdy       = 1'b0;
    start_o   = 1'b0;
    timeout_o = 1'b0;
    unique case (state_q)
      StLoadW, StLoadX: begin
        rdy = 1'b1;
        if (s_valid_i) begin
          w_wr_d    = (state_q == StLoadW);
          x_wr_d    = (state_q == StLoadX);
          wr_addr_d = cnt_q;
          wr_data_d = s_data_i;
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = (state_q == StLoadW) ? StLoadX : StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: state_d = StKick;
      StKick: begin
        start_o = 1'b1;
        tmo_d   = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // done_i on the expiry cycle wins over the watchdog
        if (done_i) begin
          m_data_d  = acc_i;
          m_valid_d = 1'b1;
          state_d   = StResult;
        end else if (TmoEn && tmo_q == TmoLast) begin
          timeout_o = 1'b1;
          state_d   = StLoadW;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResult: begin
        if (m_ready_i) begin
          m_valid_d = 1'b0;
          state_d   = StLoadW;
        end
      end
      default: state_d = StLoadW;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StLoadW;
      cnt_q     <= '0;
      w_wr_q    <= 1'b0;
      x_wr_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_wr_q    <= w_wr_d;
      x_wr_q    <= x_wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      tmo_q     <= tmo_d;
    end
  end

  // Ready is masked during reset so every output reads 0 while rst_i is held.
  assign s_ready_o = rdy & ~rst_i;
  assign w_en_o    = w_wr_q;
  assign w_we_o    = w_wr_q;
  assign w_addr_o  = wr_addr_q;
  assign w_din_o   = wr_data_q;
  assign x_en_o    = x_wr_q;
  assign x_we_o    = x_wr_q;
  assign x_addr_o  = wr_addr_q;
  assign x_din_o   = wr_data_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign busy_o    = !(state_q == StLoadW && cnt_q == '0);

endmodule
